// File: rtl/ram_arbiter_if.sv
// ============================================================================
// Module   : ram_arbiter_if
// Purpose  : Bundles the CPU request, auxiliary request and single-port RAM
//            signals of ram_arbiter. The slave modport is the arbiter; the
//            master modport is the surrounding system (CPU, aux master, RAM).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_arbiter_if;
    // CPU memory-stage port
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_stall;
    logic        cpu_rvalid;
    logic [15:0] cpu_rdata;

    // Auxiliary master port
    logic        aux_req;
    logic        aux_we;
    logic [15:0] aux_addr;
    logic [15:0] aux_wdata;
    logic        aux_gnt;
    logic        aux_rvalid;
    logic [15:0] aux_rdata;

    // Single-port RAM port (ram_q is registered, valid one cycle after address)
    logic [15:0] ram_q;
    logic [15:0] ram_address;
    logic [15:0] ram_data;
    logic        ram_wren;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  aux_req, aux_we, aux_addr, aux_wdata,
        input  ram_q,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        output aux_gnt, aux_rvalid, aux_rdata,
        output ram_address, ram_data, ram_wren
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output aux_req, aux_we, aux_addr, aux_wdata,
        output ram_q,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        input  aux_gnt, aux_rvalid, aux_rdata,
        input  ram_address, ram_data, ram_wren
    );
endinterface

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Shares one single-port RAM between the CPU memory stage and an
//            auxiliary master. Each access takes three cycles:
//            IDLE (arbitrate + latch) -> *_ACC (drive RAM) -> *_ACK (complete).
//            Ties are resolved round-robin by default; defining the macro
//            ARB_CPU_PRIORITY_EN makes the CPU win every tie instead.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter (
    input  logic          clk,
    input  logic          reset,
    ram_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CPU_ACC = 3'd1,
        AUX_ACC = 3'd2,
        CPU_ACK = 3'd3,
        AUX_ACK = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_grant_cpu;
    logic        w_grant_aux;

    // Access captured at grant time; the RAM is driven only from these so the
    // requester may change or drop its inputs once granted.
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_we;

    logic [15:0] r_cpu_rdata;
    logic [15:0] r_aux_rdata;

`ifndef ARB_CPU_PRIORITY_EN
    localparam logic c_GRANT_CPU = 1'b0;
    localparam logic c_GRANT_AUX = 1'b1;

    // Owner of the most recent grant; resets to AUX so the CPU wins the first tie
    logic        r_last_grant;
`endif

    // Arbitration, next-state decode and all RAM/handshake outputs
    always_comb begin
        w_grant_cpu     = 1'b0;
        w_grant_aux     = 1'b0;
        w_state_nxt     = r_state;
        bus.ram_address = r_addr;
        bus.ram_data    = r_wdata;
        bus.ram_wren    = 1'b0;
        bus.cpu_rvalid  = 1'b0;
        bus.aux_rvalid  = 1'b0;
        bus.cpu_rdata   = r_cpu_rdata;
        bus.aux_rdata   = r_aux_rdata;

        case (r_state)
            IDLE: begin
                if (bus.cpu_req && bus.aux_req) begin
`ifdef ARB_CPU_PRIORITY_EN
                    w_grant_cpu = 1'b1;
`else
                    if (r_last_grant == c_GRANT_AUX) begin
                        w_grant_cpu = 1'b1;
                    end else begin
                        w_grant_aux = 1'b1;
                    end
`endif
                end else if (bus.cpu_req) begin
                    w_grant_cpu = 1'b1;
                end else if (bus.aux_req) begin
                    w_grant_aux = 1'b1;
                end

                if (w_grant_cpu) begin
                    w_state_nxt = CPU_ACC;
                end else if (w_grant_aux) begin
                    w_state_nxt = AUX_ACC;
                end
            end
            CPU_ACC: begin
                bus.ram_wren = r_we;
                w_state_nxt  = CPU_ACK;
            end
            AUX_ACC: begin
                bus.ram_wren = r_we;
                w_state_nxt  = AUX_ACK;
            end
            CPU_ACK: begin
                bus.cpu_rvalid = 1'b1;
                // RAM output is valid this cycle; forward it so rdata
                // accompanies the rvalid pulse
                if (!r_we) begin
                    bus.cpu_rdata = bus.ram_q;
                end
                w_state_nxt = IDLE;
            end
            AUX_ACK: begin
                bus.aux_rvalid = 1'b1;
                if (!r_we) begin
                    bus.aux_rdata = bus.ram_q;
                end
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // aux_gnt marks the cycle in which the aux inputs are captured
        bus.aux_gnt   = w_grant_aux;
        bus.cpu_stall = bus.cpu_req & ~bus.cpu_rvalid;
    end

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the winner's access at grant time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= 16'h0000;
            r_wdata <= 16'h0000;
            r_we    <= 1'b0;
        end else if (w_grant_cpu) begin
            r_addr  <= bus.cpu_addr;
            r_wdata <= bus.cpu_wdata;
            r_we    <= bus.cpu_we;
        end else if (w_grant_aux) begin
            r_addr  <= bus.aux_addr;
            r_wdata <= bus.aux_wdata;
            r_we    <= bus.aux_we;
        end
    end

`ifndef ARB_CPU_PRIORITY_EN
    // Remember who was granted last for round-robin tie breaking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= c_GRANT_AUX;
        end else if (w_grant_cpu) begin
            r_last_grant <= c_GRANT_CPU;
        end else if (w_grant_aux) begin
            r_last_grant <= c_GRANT_AUX;
        end
    end
`endif

    // Hold the last read data of each owner; writes leave it unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_rdata <= 16'h0000;
            r_aux_rdata <= 16'h0000;
        end else begin
            if (r_state == CPU_ACK && !r_we) begin
                r_cpu_rdata <= bus.ram_q;
            end
            if (r_state == AUX_ACK && !r_we) begin
                r_aux_rdata <= bus.ram_q;
            end
        end
    end

endmodule

`default_nettype wire
